fila_controller: RTL

FILA_CONTROLLER -- requirements
Module: fila_controller

---
 rtl/fila_controller.sv | 94 +++++++++
 1 files changed

// File: rtl/fila_controller.sv
// Enqueue/dequeue sequencer for fila: synchronises data_ready, handshakes with the deserializador and arbitrates strobes.
// Enqueue strobe 3 edges after data_ready (SYNC_STAGES=2); a full queue holds the FSM in STALL; a dequeue is deferred behind an enqueue.
module fila_controller #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       data_ready,
  input  logic [7:0] len_out,
  input  logic       dequeue_req,
  output logic       enqueue_in,
  output logic       dequeue_in,
  output logic       ack_in,
  output logic       full,
  output logic       empty,
  output logic [7:0] enq_count,
  output logic [7:0] stall_count
);

  typedef enum logic [1:0] {IDLE, STALL, ENQ, ACK} state_t;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_s;
  logic                   dq_prev_q;
  logic                   pending_q, pending_d;
  logic                   dequeue_q, dequeue_d;
  logic [7:0]             enq_count_q, stall_count_q;
  logic                   dq_rise, pend_eff;

  assign rdy_s   = sync_q[SYNC_STAGES-1];
  assign full    = ({1'b0, len_out} >= DEPTH_W);
  assign empty   = (len_out == 8'd0);
  assign dq_rise = dequeue_req & ~dq_prev_q;
  assign pend_eff = pending_q | dq_rise;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rdy_s) state_d = full ? STALL : ENQ;
      STALL:   if (!full) state_d = ENQ;
      ENQ:     state_d = ACK;
      ACK:     if (!rdy_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is judged against the next state so the registered dequeue strobe can never land on an enqueue cycle.
  always_comb begin
    pending_d = pending_q;
    dequeue_d = 1'b0;
    if (pend_eff) begin
      if (empty) begin
        pending_d = 1'b0;
      end else if (state_d != ENQ && !dequeue_q) begin
        dequeue_d = 1'b1;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      dq_prev_q     <= 1'b0;
      pending_q     <= 1'b0;
      dequeue_q     <= 1'b0;
      enq_count_q   <= 8'd0;
      stall_count_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], data_ready};
      dq_prev_q <= dequeue_req;
      pending_q <= pending_d;
      dequeue_q <= dequeue_d;
      if (state_q == ENQ) enq_count_q <= enq_count_q + 8'd1;
      if (state_q == IDLE && state_d == STALL && stall_count_q != 8'hFF)
        stall_count_q <= stall_count_q + 8'd1;
    end
  end

  assign enqueue_in  = (state_q == ENQ);
  assign ack_in      = (state_q == ACK);
  assign dequeue_in  = dequeue_q;
  assign enq_count   = enq_count_q;
  assign stall_count = stall_count_q;

endmodule
